// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - single-port memory bus slave with fixed ack latency and transfer counters
module mem_bus_responder #(
    parameter int BUS_WIDTH_BYTES = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int DEPTH_WORDS     = 256,
    parameter int LATENCY         = 0
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic [ADDR_WIDTH-1:0]        addr_i,
    input  logic [BUS_WIDTH_BYTES*8-1:0] wdata_i,
    output logic [BUS_WIDTH_BYTES*8-1:0] rdata_o,
    output logic                         ack_o,
    input  logic                         clear_counts_i,
    output logic [31:0]                  rd_count_o,
    output logic [31:0]                  wr_count_o
);

    localparam int DW   = BUS_WIDTH_BYTES * 8;
    localparam int OFFS = $clog2(BUS_WIDTH_BYTES);
    localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wait_q, wait_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DW-1:0]           wdata_q, wdata_d;
    logic [DW-1:0]           rdata_q, rdata_d;
    logic [31:0]             rd_cnt_q, rd_cnt_d;
    logic [31:0]             wr_cnt_q, wr_cnt_d;
    logic [DW-1:0]           mem_q [DEPTH_WORDS];

    logic [IDXW-1:0]         rd_idx;
    logic [IDXW-1:0]         wr_idx;
    logic                    ack;

    // addr_d already holds the incoming address on a capture, so a LATENCY=0
    // read can fetch its word on the same edge that captures it.
    assign rd_idx = IDXW'(addr_d >> OFFS);
    assign wr_idx = IDXW'(addr_q >> OFFS);
    assign ack    = (state_q == S_ACK);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    if (LATENCY == 0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        wait_d  = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rdata_d  = rdata_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (state_d == S_ACK && state_q != S_ACK && !we_d) begin
            rdata_d = mem_q[rd_idx];
        end
        if (clear_counts_i) begin
            rd_cnt_d = 32'd0;
            wr_cnt_d = 32'd0;
        end else if (ack && we_q) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end else if (ack) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            wait_q   <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Storage has no reset; a write whose ack edge is also a reset edge is dropped.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && ack && we_q) begin
            mem_q[wr_idx] <= wdata_q;
        end
    end

    assign rdata_o    = rdata_q;
    assign ack_o      = ack;
    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;

endmodule
